divider_seq: RTL and testbench
==============================

// Module: divider_seq
// PURPOSE
//  Iterative unsigned N-bit restoring divider, one quotient bit per cycle.
//  Each step is a trial subtraction of the divisor from the partial remainder.
//  Sits downstream of operand decode, alongside the ALU's subtract/compare
//  path, and serves DIVU/REMU-style ops.
//  Uses valid/ready on both the operand side and the result side.
// PARAMETERS
//  N  32  operand/result width in bits; N >= 2
// PORTS
//  clk           input   1  clock; all state updates on rising edge
//  rst           input   1  reset, asynchronous, active-low
//  i_valid       input   1  operands present on dividend/divisor
//  o_ready       output  1  divider can accept operands
//  dividend      input   N  unsigned dividend
//  divisor       input   N  unsigned divisor
//  o_valid       output  1  quotient/remainder/div_by_zero valid
//  i_ready       input   1  consumer takes the result
//  quotient      output  N  unsigned quotient
//  remainder     output  N  unsigned remainder
//  div_by_zero   output  1  set when divisor == 0 for this result
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE; o_ready=1; o_valid=0
//   - quotient, remainder, div_by_zero and internal count all 0
//  States: IDLE, RUN, DONE.
//  IDLE
//   - o_ready=1, o_valid=0
//   - Accept on rising edge with i_valid&o_ready; latch both operands.
//   - divisor!=0: rem=0, q=dividend, count=0, go to RUN.
//   - divisor==0: go straight to DONE with quotient={N{1'b1}},
//     remainder=dividend, div_by_zero=1.
//  RUN (o_ready=0, o_valid=0), one step per cycle:
//   - t = {rem, q[N-1]}, N+1 bits.
//   - d = t - {1'b0, divisor}; N+1-bit subtract via adder_n with inverted
//     operand and c_in=1.
//   - No borrow: rem=d[N-1:0], and q shifts left with a 1 entering the LSB.
//   - Borrow: rem=t[N-1:0], and q shifts left with a 0 entering the LSB.
//   - count++; after step N-1 (N steps total) go to DONE.
//   - Register quotient=q and remainder=rem; div_by_zero=0.
//  DONE
//   - o_valid=1, o_ready=0.
//   - quotient, remainder and div_by_zero held stable while i_ready=0.
//   - On rising edge with o_valid&i_ready go to IDLE; o_valid drops that edge.
//   - Outputs keep their last values until the next result is registered.
//  Latency, counted from the accept edge:
//   - o_valid is high after edge N+1 (divisor!=0).
//   - o_valid is high after edge 1 (divisor==0).
//  Throughput: one op per N+2 cycles minimum. No new accept in RUN or DONE;
//   the same-cycle result handoff plus new accept is NOT supported.
//  Operand changes after accept have no effect; i_valid in RUN/DONE is ignored.
//  Reset mid-RUN or mid-DONE:
//   - The in-flight op is discarded, with no partial o_valid.
//   - The first edge after rst deasserts behaves as IDLE.
//  Invariant in DONE with divisor!=0:
//   - quotient*divisor + remainder == dividend
//   - remainder < divisor
// TESTING
//  1 100/7 -> quotient=14, remainder=2, div_by_zero=0, o_valid after edge N+1
//  2 32'hFFFF_FFFF/1 -> quotient=32'hFFFF_FFFF, remainder=0;
//    3/10 -> quotient=0, remainder=3
//  3 5/0 -> o_valid after edge 1, quotient=32'hFFFF_FFFF, remainder=5,
//    div_by_zero=1
//  4 i_ready held 0 for 5 cycles in DONE -> all outputs stable, o_ready=0;
//    i_ready=1 -> IDLE next edge
//  5 rst pulsed low at RUN step 10 of 1000/3 -> o_valid=0, o_ready=1
//    immediately; next op 1000/3 -> quotient=333, remainder=1
//  6 2000 random operand pairs incl. 0, 1, MSB-set and divisor>dividend
//    -> invariant holds, div_by_zero only when divisor==0

Source files
------------

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
// A zero divisor skips iteration and returns all-ones quotient with the dividend as remainder.
module divider_seq #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      rem_q, rem_d;
    logic [N-1:0]      q_q, q_d;
    logic [N-1:0]      dsr_q, dsr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [N-1:0]      quotient_q, quotient_d;
    logic [N-1:0]      remainder_q, remainder_d;
    logic              dbz_q, dbz_d;

    logic [N:0]        trial;
    logic [N:0]        diff;
    logic              no_borrow;

    // Trial subtraction as an adder with inverted divisor and carry-in of one;
    // carry-out set means the divisor fits into the shifted partial remainder.
    assign trial = {rem_q, q_q[N-1]};
    assign {no_borrow, diff} = {1'b0, trial} + {1'b0, ~{1'b0, dsr_q}}
                               + {{(N + 1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dsr_d       = dsr_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    dsr_d = divisor;
                    if (divisor != '0) begin
                        rem_d   = '0;
                        q_d     = dividend;
                        count_d = '0;
                        state_d = StRun;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end
                end
            end
            StRun: begin
                rem_d   = no_borrow ? diff[N-1:0] : trial[N-1:0];
                q_d     = {q_q[N-2:0], no_borrow};
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(N - 1)) begin
                    quotient_d  = q_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            q_q         <= '0;
            dsr_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dsr_q       <= dsr_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign o_ready     = (state_q == StIdle);
    assign o_valid     = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomised checks of divider_seq: latency, result values, hold in DONE,
// asynchronous reset mid-operation and the division invariant.
module tb_divider_seq;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    divider_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for the result, optionally stall the consumer, then hand off.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                          input logic exp_dbz, input int exp_lat, input int hold);
        int edges;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        i_valid  = 1'b1;
        @(negedge clk);
        edges    = 1;
        i_valid  = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        check("busy_after_accept", 64'(o_ready), 64'(0));
        while (!o_valid && edges < 4 * N) begin
            @(negedge clk);
            edges++;
        end
        check("latency", 64'(edges), 64'(exp_lat));
        check("quotient", 64'(quotient), 64'(exp_q));
        check("remainder", 64'(remainder), 64'(exp_r));
        check("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
        check("ready_in_done", 64'(o_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 64'(o_valid), 64'(1));
            check("hold_ready", 64'(o_ready), 64'(0));
            check("hold_quotient", 64'(quotient), 64'(exp_q));
            check("hold_remainder", 64'(remainder), 64'(exp_r));
            check("hold_dbz", 64'(div_by_zero), 64'(exp_dbz));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("handoff_valid", 64'(o_valid), 64'(0));
        check("handoff_ready", 64'(o_ready), 64'(1));
        check("keep_quotient", 64'(quotient), 64'(exp_q));
    endtask

    function automatic logic [N-1:0] pick(input int cls);
        logic [N-1:0] v;
        v = $urandom;
        case (cls)
            0:       return '0;
            1:       return {{(N - 1){1'b0}}, 1'b1};
            2:       return {1'b1, v[N-2:0]};
            3:       return N'($urandom_range(0, 100));
            default: return v;
        endcase
    endfunction

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic [N-1:0] er;

        // Reset state
        #2;
        check("rst_ready", 64'(o_ready), 64'(1));
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_quotient", 64'(quotient), 64'(0));
        check("rst_remainder", 64'(remainder), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, N + 1, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, N + 1, 0);
        run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, N + 1, 0);
        run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
        run_op(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, N + 1, 5);
        run_op(32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, 1, 5);
        run_op(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, N + 1, 0);

        // Reset during RUN step 10
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        i_valid  = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrun_rst_valid", 64'(o_valid), 64'(0));
        check("midrun_rst_ready", 64'(o_ready), 64'(1));
        check("midrun_rst_quotient", 64'(quotient), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        check("post_rst_valid", 64'(o_valid), 64'(0));
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, N + 1, 0);

        for (int n = 0; n < 2000; n++) begin
            a = pick($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0 && a != '1) begin
                b = a + N'(1);
            end else begin
                b = pick($urandom_range(0, 5));
            end
            if (b == '0) begin
                eq = '1;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op(a, b, eq, er, (b == '0), (b == '0) ? 1 : N + 1, 0);
            if (b != '0) begin
                check("invariant_sum", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
                check("invariant_rem_lt", 64'(remainder < b), 64'(1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
